// File: rtl/dm_resp.sv
// dm_resp -- single-outstanding data-memory responder with programmable wait states.
//
// A request is accepted in IDLE. It waits WAIT_CYCLES extra cycles in WAIT. The
// access then happens on the next edge, and the response is held in RESP until
// rsp_ready_i.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   req_valid_i/req_ready_o request handshake (ready only in IDLE)
//   req_write_i             1 = store, 0 = load
//   req_addr_i              byte address (word aligned, < DEPTH_WORDS*4)
//   req_wdata_i, req_be_i   store data and byte enables
//   rsp_valid_o/rsp_ready_i response handshake
//   rsp_rdata_o             load data (0 for stores and errors)
//   rsp_err_o               misaligned or out-of-range request
module dm_resp #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [3:0]  req_be_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        mem_we;
   logic        acc_err;
   logic [AW-1:0] idx;

   // Storage has no reset; contents are undefined until written.
   logic [31:0] mem_q [DEPTH_WORDS];

   // Decode from the latched copy only; live request inputs never reach the access.
   assign idx     = addr_q[AW+1:2];
   assign acc_err = (addr_q[1:0] != 2'b00) || (|addr_q[31:AW+2]);

   assign req_ready_o = (state_q == S_IDLE);
   assign rsp_valid_o = (state_q == S_RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      mem_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               write_d = req_write_i;
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               be_d    = req_be_i;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               // Access edge: the load sees the array contents before this edge.
               state_d = S_RESP;
               err_d   = acc_err;
               rdata_d = (!write_q && !acc_err) ? mem_q[idx] : 32'h0;
               mem_we  = write_q && !acc_err;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               state_d = S_IDLE;
               rdata_d = 32'h0;
               err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         be_q    <= 4'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // mem_we derives from reset state, so a reset during WAIT suppresses the store.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be_q[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

endmodule

// File: doc/dm_resp.md
DM_RESP -- requirements
Module: dm_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two, 4..4096).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra wait states inserted before each access (0..15).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  initiator presents a request.
REQ-007 req_ready  out  1  responder can accept a request.
REQ-008 req_write  in  1  1 = store, 0 = load.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data.
REQ-011 req_be  in  4  byte enables for stores; bit i covers bits 8i+7:8i; ignored for loads.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  initiator consumes the response.
REQ-014 rsp_rdata  out  32  load data; 0 for stores and errors.
REQ-015 rsp_err  out  1  request was misaligned or out of range.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; no combinational path from req_valid to req_ready.
REQ-018 Request SHALL be accepted on a rising edge where req_valid and req_ready are both 1: latch write, addr, wdata, be; load wait counter with WAIT_CYCLES; go IDLE->WAIT.
REQ-019 In WAIT, counter nonzero: decrement, stay in WAIT.
REQ-020 In WAIT, counter zero: perform access on that edge, load rsp registers, go WAIT->RESP.
REQ-021 Latency SHALL be WAIT_CYCLES+1 cycles from accept edge to first cycle with rsp_valid=1.
REQ-022 rsp_valid SHALL be 1 exactly in RESP; rsp_rdata and rsp_err SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-023 On an edge with rsp_valid=1 and rsp_ready=1: go RESP->IDLE; clear rsp_valid, rsp_rdata, rsp_err to 0.
REQ-024 One bubble cycle SHALL exist between back-to-back requests; max throughput one request per WAIT_CYCLES+3 cycles.
REQ-025 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2].
REQ-026 Error condition: addr[1:0] != 0, or addr[31:2] >= DEPTH_WORDS.
REQ-027 On error: no memory modification; rsp_err=1; rsp_rdata=0.
REQ-028 Valid store SHALL write only enabled bytes; req_be=0000 is legal and writes nothing; rsp_err=0; rsp_rdata=0.
REQ-029 Valid load SHALL return the full word as stored before the access edge; rsp_err=0.
REQ-030 Request inputs SHALL be ignored outside IDLE; the latched copy governs the access.
REQ-031 Storage array SHALL NOT be reset; contents are undefined until written.

Reset
REQ-032 While reset=0: state IDLE, wait counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, asynchronously.
REQ-033 Reset asserted in WAIT SHALL abort the request; a store not yet at its access edge SHALL not modify memory.
REQ-034 Reset asserted in RESP SHALL drop the pending response without handshake.
REQ-035 First request SHALL be accepted on the first rising edge after reset deasserts with req_valid=1.

Verification
REQ-036 WAIT_CYCLES=2: store addr 0x10, wdata 0xDEADBEEF, be 1111; then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid first high 3 cycles after each accept edge.
REQ-037 Byte enables: store 0x11223344 to 0x20, be 1111; store 0xAABBCCDD, be 0101; load 0x20 -> 0x11BB33DD.
REQ-038 Errors: load 0x22 -> rsp_err=1, rsp_rdata=0; store 0x400 (DEPTH_WORDS=256) -> rsp_err=1, array unchanged (word 0 read back unchanged).
REQ-039 Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_valid, rsp_rdata, rsp_err stable, req_ready=0; release -> IDLE next cycle, req_ready=1.
REQ-040 Reset mid-operation: accept store 0x55AA55AA to 0x30 over prior 0x00000001, assert reset during WAIT -> outputs at reset values immediately; after release, load 0x30 -> 0x00000001.
REQ-041 WAIT_CYCLES=0: load accepted at edge T -> rsp_valid=1 in the cycle after edge T+1; req_ready=0 until the response handshake completes.
